// File: rtl/sram22_generic.sv
// -----------------------------------------------------------------------------
// sram22_generic
//
// Purpose:
//   Single-port, byte-lane-maskable synchronous SRAM model with a built-in
//   power-on zeroing sweep. After reset the block writes zero to every word,
//   one word per cycle, before it accepts accesses. Reads are registered. The
//   base read latency is 1 cycle. An optional extra output register stage
//   gives a latency of 2 cycles.
//
// Optional feature:
//   SRAM22_DOUT_PIPE_EN  - when defined, adds the extra output register stage.
//                          Read latency becomes 2 cycles and throughput is
//                          unchanged.
//
// Ports:
//   clk         in   1            clock, all state on rising edge
//   rstb        in   1            asynchronous active-low reset
//   ce          in   1            chip enable (access request)
//   we          in   1            1 = write, 0 = read
//   wmask       in   WMASK_WIDTH  per-lane write enable, lane i = [i*LW +: LW]
//   addr        in   ADDR_WIDTH   word address
//   din         in   DATA_WIDTH   write data
//   dout        out  DATA_WIDTH   registered read data (holds between reads)
//   dout_valid  out  1            one-cycle pulse marking new dout
//   ready       out  1            1 once the init sweep has completed
//   access_err  out  1            one-cycle pulse: access attempted during init
// -----------------------------------------------------------------------------
module sram22_generic #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready,
    output logic                   access_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = DATA_WIDTH / WMASK_WIDTH;

    // The counter is one bit wider than the address. The last sweep word is
    // then detected by an exact compare and never by a wrap back to zero.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_lane_width
        $error("sram22_generic: DATA_WIDTH (%0d) must be divisible by WMASK_WIDTH (%0d)",
               DATA_WIDTH, WMASK_WIDTH);
    end

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic                    access_err_q, access_err_d;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [WMASK_WIDTH-1:0]  mem_lane_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    rd_en;

    // Next-state and memory write-port control. The init sweep and the normal
    // write path share the single write port. The FSM state selects the owner.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // can leave one unassigned and infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_lane_we  = '0;
        mem_waddr    = addr;
        mem_wdata    = din;
        rd_en        = 1'b0;
        access_err_d = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                mem_lane_we  = '1;
                mem_waddr    = cnt_q[ADDR_WIDTH-1:0];
                mem_wdata    = '0;
                access_err_d = ce;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ce && we) begin
                    mem_lane_we = wmask;
                end
                rd_en = ce && !we;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // NOTE: the array has no reset. It is zeroed only by the init sweep. A
    // resettable array would force every bit into a flop with a reset pin.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (mem_lane_we[i] && rstb) begin
                mem[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            access_err_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            access_err_q <= access_err_d;
            rd_valid_q   <= rd_en;
            // The read register holds its value when no read is issued.
            if (rd_en) begin
                rd_data_q <= mem[addr];
            end
        end
    end

`ifdef SRAM22_DOUT_PIPE_EN
    logic [DATA_WIDTH-1:0] pipe_data_q;
    logic                  pipe_valid_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
        end else begin
            pipe_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                pipe_data_q <= rd_data_q;
            end
        end
    end

    assign dout       = pipe_data_q;
    assign dout_valid = pipe_valid_q;
`else
    assign dout       = rd_data_q;
    assign dout_valid = rd_valid_q;
`endif

    assign ready      = (state_q == ST_RUN);
    assign access_err = access_err_q;

endmodule

// File: tb/tb_sram22_generic.sv
// -----------------------------------------------------------------------------
// tb_sram22_generic
//
// Self-checking bench for sram22_generic. It exercises two instances:
//   dut_a : DATA_WIDTH=32, ADDR_WIDTH=8, WMASK_WIDTH=4 (256 words, 8-bit lanes)
//   dut_b : DATA_WIDTH=64, ADDR_WIDTH=4, WMASK_WIDTH=8 (16 words, 8-bit lanes)
// The instances are tested one after the other. Read expectations are pushed
// to a per-instance queue when a read is issued. Each entry carries the cycle
// on which the data must appear. A negedge monitor pops an entry and compares
// it whenever dout_valid is seen.
// -----------------------------------------------------------------------------
module tb_sram22_generic;

`ifdef SRAM22_DOUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        we;
        logic [7:0]  wmask;
        logic [7:0]  addr;
        logic [63:0] din;
        logic [63:0] exp;   // expected read data (reads only)
    } vec_t;

    typedef vec_t tbl_t [12];

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstb_a, rstb_b, ce_a, ce_b, we;
    logic [7:0]  wmask, addr;
    logic [63:0] din;

    logic [31:0] dout_a;
    logic [63:0] dout_b;
    logic        dv_a, dv_b, ready_a, ready_b, err_a, err_b;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_a [$];
    exp_t q_b [$];
    tbl_t va, vb;

    sram22_generic #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4)) dut_a (
        .clk(clk), .rstb(rstb_a), .ce(ce_a), .we(we), .wmask(wmask[3:0]),
        .addr(addr), .din(din[31:0]), .dout(dout_a), .dout_valid(dv_a),
        .ready(ready_a), .access_err(err_a)
    );

    sram22_generic #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(8)) dut_b (
        .clk(clk), .rstb(rstb_b), .ce(ce_b), .we(we), .wmask(wmask),
        .addr(addr[3:0]), .din(din), .dout(dout_b), .dout_valid(dv_b),
        .ready(ready_b), .access_err(err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] dout_of(input int s);
        return (s != 0) ? dout_b : {32'h0, dout_a};
    endfunction
    function automatic logic dv_of(input int s);
        return (s != 0) ? dv_b : dv_a;
    endfunction
    function automatic logic ready_of(input int s);
        return (s != 0) ? ready_b : ready_a;
    endfunction
    function automatic logic err_of(input int s);
        return (s != 0) ? err_b : err_a;
    endfunction
    function automatic logic [63:0] flags_of(input int s);
        return {61'h0, ready_of(s), dv_of(s), err_of(s)};
    endfunction

    task automatic set_rstb(input int s, input logic v);
        if (s != 0) rstb_b = v; else rstb_a = v;
        // In-flight reads are discarded by reset, so their expectations are too.
        if (!v) begin
            if (s != 0) q_b.delete(); else q_a.delete();
        end
    endtask

    task automatic set_ce(input int s, input logic v);
        if (s != 0) ce_b = v; else ce_a = v;
    endtask

    task automatic mon(input int s);
        exp_t e;
        int   pending;
        if (dv_of(s)) begin
            pending = (s != 0) ? q_b.size() : q_a.size();
            if (pending == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_valid dut%0d @cyc %0d: dout=%h, no read outstanding",
                         s, cyc, dout_of(s));
            end else begin
                if (s != 0) e = q_b.pop_front(); else e = q_a.pop_front();
                check("sb_data", dout_of(s), e.data);
                check("sb_latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Release reset and follow the init sweep edge by edge. If err_at > 0, a
    // read request is driven during the cycle after edge err_at. access_err
    // must then pulse after edge err_at+1 only.
    task automatic run_init(input int s, input int err_at);
        int depth = (s != 0) ? 16 : 256;
        int early = 0, bad_err = 0, bad_out = 0;
        @(posedge clk); #1;
        set_rstb(s, 1'b1);
        for (int k = 1; k <= depth; k++) begin
            @(posedge clk); #1;
            set_ce(s, k == err_at);
            we   = 1'b0;
            addr = 8'h05;
            @(negedge clk);
            if (k < depth && ready_of(s)) early++;
            if (err_of(s) !== (err_at > 0 && k == err_at + 1)) bad_err++;
            if (dv_of(s) !== 1'b0 || dout_of(s) !== 64'h0) bad_out++;
        end
        check("init_ready_at_depth", 64'(ready_of(s)), 64'd1);
        check("init_ready_early_cycles", 64'(early), 64'd0);
        check("init_access_err_pulse", 64'(bad_err), 64'd0);
        check("init_dout_quiet", 64'(bad_out), 64'd0);
    endtask

    task automatic apply_vec(input int s, input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        set_ce(s, 1'b1);
        we    = v.we;
        wmask = v.wmask;
        addr  = v.addr;
        din   = v.din;
        if (!v.we) begin
            e.data = v.exp;
            e.due  = cyc + LAT;
            if (s != 0) q_b.push_back(e); else q_a.push_back(e);
        end
    endtask

    task automatic idle_and_drain(input int s);
        @(posedge clk); #1;
        set_ce(s, 1'b0);
        repeat (LAT + 2) @(negedge clk);
        check("sb_drained", 64'((s != 0) ? q_b.size() : q_a.size()), 64'd0);
    endtask

    task automatic run_suite(input int s, input tbl_t t);
        vec_t rd;
        // Reset state while rstb is held low.
        @(negedge clk);
        check("reset_dout", dout_of(s), 64'h0);
        check("reset_flags", flags_of(s), 64'h0);

        // Sweep with an access attempt during init.
        run_init(s, 10);

        // Table of writes and reads, one access per cycle.
        for (int i = 0; i < 12; i++) apply_vec(s, t[i]);
        idle_and_drain(s);

        // dout must hold the last read while dout_valid stays low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_dout_valid", 64'(dv_of(s)), 64'd0);
            check("hold_dout", dout_of(s), t[11].exp);
        end

        // Reset during a read in flight: outputs clear without a clock edge.
        @(posedge clk); #1;
        set_ce(s, 1'b1);
        we   = 1'b0;
        addr = t[2].addr;
        @(posedge clk); #1;
        set_ce(s, 1'b0);
        set_rstb(s, 1'b0);
        #1;
        check("midread_rst_dout", dout_of(s), 64'h0);
        check("midread_rst_flags", flags_of(s), 64'h0);
        run_init(s, 0);

        // The sweep has re-zeroed the word that was written earlier.
        rd = '{1'b0, 8'h00, t[2].addr, 64'h0, 64'h0};
        apply_vec(s, rd);
        idle_and_drain(s);

        // Reset in the middle of the sweep restarts it from word 0.
        @(posedge clk); #1;
        set_rstb(s, 1'b1);
        repeat ((s != 0) ? 8 : 100) @(posedge clk);
        #1;
        set_rstb(s, 1'b0);
        #1;
        check("midsweep_rst_flags", flags_of(s), 64'h0);
        run_init(s, 0);
    endtask

    initial begin
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        ce_a   = 1'b0;
        ce_b   = 1'b0;
        we     = 1'b0;
        wmask  = '0;
        addr   = '0;
        din    = '0;
        #1;
        rstb_a = 1'b0;
        rstb_b = 1'b0;

        //          we    wmask  addr   din                      expected read
        va[0]  = '{1'b1, 8'h0F, 8'h10, 64'hDEADBEEF,           64'h0};
        va[1]  = '{1'b1, 8'h05, 8'h10, 64'h11223344,           64'h0};
        va[2]  = '{1'b0, 8'h00, 8'h10, 64'h0,                  64'hDE22BE44};
        va[3]  = '{1'b1, 8'h0F, 8'hFF, 64'hCAFEF00D,           64'h0};
        va[4]  = '{1'b0, 8'h00, 8'hFF, 64'h0,                  64'hCAFEF00D};
        va[5]  = '{1'b0, 8'h00, 8'h00, 64'h0,                  64'h0};
        va[6]  = '{1'b0, 8'h00, 8'h01, 64'h0,                  64'h0};
        va[7]  = '{1'b0, 8'h00, 8'h5A, 64'h0,                  64'h0};
        va[8]  = '{1'b1, 8'h00, 8'h20, 64'h12345678,           64'h0};
        va[9]  = '{1'b0, 8'h00, 8'h20, 64'h0,                  64'h0};
        va[10] = '{1'b1, 8'h0A, 8'h20, 64'hAABBCCDD,           64'h0};
        va[11] = '{1'b0, 8'h00, 8'h20, 64'h0,                  64'hAA00CC00};

        vb[0]  = '{1'b1, 8'hFF, 8'h03, 64'h0123456789ABCDEF,   64'h0};
        vb[1]  = '{1'b1, 8'h55, 8'h03, 64'hFFEEDDCCBBAA9988,   64'h0};
        vb[2]  = '{1'b0, 8'h00, 8'h03, 64'h0,                  64'h01EE45CC89AACD88};
        vb[3]  = '{1'b1, 8'hFF, 8'h0F, 64'hCAFEF00DCAFEF00D,   64'h0};
        vb[4]  = '{1'b0, 8'h00, 8'h0F, 64'h0,                  64'hCAFEF00DCAFEF00D};
        vb[5]  = '{1'b0, 8'h00, 8'h00, 64'h0,                  64'h0};
        vb[6]  = '{1'b0, 8'h00, 8'h01, 64'h0,                  64'h0};
        vb[7]  = '{1'b0, 8'h00, 8'h0A, 64'h0,                  64'h0};
        vb[8]  = '{1'b1, 8'h00, 8'h05, 64'h0000000000000123,   64'h0};
        vb[9]  = '{1'b0, 8'h00, 8'h05, 64'h0,                  64'h0};
        vb[10] = '{1'b1, 8'h81, 8'h05, 64'h1111111111111111,   64'h0};
        vb[11] = '{1'b0, 8'h00, 8'h05, 64'h0,                  64'h1100000000000011};

        run_suite(0, va);
        set_rstb(0, 1'b0);
        run_suite(1, vb);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
